// File: rtl/frame_stream_loader.sv
// Purpose: loads a LANES-pixel-per-beat valid/ready stream into a row-major HEIGHT x WIDTH frame buffer.
// Latency: img_rdy pulses 2 cycles after the last beat when det_busy is low.
// Backpressure: pix_ready drops from frame completion until the img_rdy pulse has been issued.

`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 32
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 24
`endif

module frame_stream_loader #(
  parameter int WIDTH  = `LAPTOP_WIDTH,
  parameter int HEIGHT = `LAPTOP_HEIGHT,
  parameter int PIX_W  = 8,
  parameter int LANES  = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [LANES*PIX_W-1:0]                  pix_data,
  input  logic                                    pix_valid,
  input  logic                                    pix_sof,
  output logic                                    pix_ready,
  input  logic                                    det_busy,
  output logic [HEIGHT-1:0][WIDTH-1:0][PIX_W-1:0] laptop_img,
  output logic                                    img_rdy,
  output logic                                    frame_err,
  output logic [15:0]                             frame_cnt,
  output logic [15:0]                             drop_cnt
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - LANES);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, FIRE} state_t;

  state_t                                  state_q, state_d;
  logic [RW-1:0]                           row_q, row_d;
  logic [CW-1:0]                           col_q, col_d;
  logic [HEIGHT-1:0][WIDTH-1:0][PIX_W-1:0] img_q, img_d;
  logic                                    img_rdy_q, img_rdy_d;
  logic                                    frame_err_q, frame_err_d;
  logic [15:0]                             frame_cnt_q, frame_cnt_d;
  logic [15:0]                             drop_cnt_q, drop_cnt_d;

  logic          accept;
  logic          do_write;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [CW-1:0] col_k;

  // State, position, frame buffer and counters; everything clears on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      img_q       <= '0;
      img_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      img_q       <= img_d;
      img_rdy_q   <= img_rdy_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Next-state: an sof beat always writes at (0,0), so it shares the advance logic with ordinary beats.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    img_d       = img_q;
    img_rdy_d   = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    do_write    = 1'b0;
    col_k       = '0;
    pix_ready   = (state_q == IDLE) || (state_q == LOAD);
    accept      = pix_valid && pix_ready;
    wr_row      = pix_sof ? '0 : row_q;
    wr_col      = pix_sof ? '0 : col_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pix_sof) begin
            do_write = 1'b1;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          do_write    = 1'b1;
          frame_err_d = pix_sof;
        end
      end
      HOLD: begin
        if (!det_busy) begin
          state_d     = FIRE;
          img_rdy_d   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      FIRE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_write) begin
      for (int k = 0; k < LANES; k++) begin
        col_k = wr_col + CW'(k);
        img_d[wr_row][col_k] = pix_data[k*PIX_W +: PIX_W];
      end
      if (wr_row == LAST_ROW && wr_col == LAST_COL) begin
        row_d   = '0;
        col_d   = '0;
        state_d = HOLD;
      end else if (wr_col == LAST_COL) begin
        row_d   = wr_row + RW'(1);
        col_d   = '0;
        state_d = LOAD;
      end else begin
        row_d   = wr_row;
        col_d   = wr_col + CW'(LANES);
        state_d = LOAD;
      end
    end
  end

  assign laptop_img = img_q;
  assign img_rdy    = img_rdy_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_stream_loader.sv
// Directed bench for frame_stream_loader with an 8x4 frame of 8-bit pixels, two lanes per beat.
// Each scenario task drives beats and checks outputs half a cycle or 1 ns after the clock edge.
// Expected pixels follow base + row*8 + col, so every frame is distinguishable by its base.

module tb_frame_stream_loader;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int PIX_W  = 8;
  localparam int LANES  = 2;

  logic                                    clock = 1'b0;
  logic                                    reset;
  logic [LANES*PIX_W-1:0]                  pix_data;
  logic                                    pix_valid;
  logic                                    pix_sof;
  logic                                    pix_ready;
  logic                                    det_busy;
  logic [HEIGHT-1:0][WIDTH-1:0][PIX_W-1:0] laptop_img;
  logic                                    img_rdy;
  logic                                    frame_err;
  logic [15:0]                             frame_cnt;
  logic [15:0]                             drop_cnt;

  int tests = 0;
  int fails = 0;

  frame_stream_loader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .LANES(LANES)
  ) dut (
    .clock(clock), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .det_busy(det_busy),
    .laptop_img(laptop_img), .img_rdy(img_rdy), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + r*8 + c);
  endfunction

  // Present one beat and wait (bounded) until it is accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [7:0] p0, input logic [7:0] p1, input logic sof);
    int waited;
    waited    = 0;
    pix_data  = {p1, p0};
    pix_sof   = sof;
    pix_valid = 1'b1;
    @(negedge clock);
    while (pix_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    tests++;
    if (pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL beat_accept: pix_ready=%b, required 1 within 50 cycles", pix_ready);
    end
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // Beats first..last of a frame; beat b covers row b/4, cols 2*(b%4) and +1; beat 0 carries sof.
  task automatic send_range(input int base, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      send_beat(pix(base, b/4, (b%4)*2), pix(base, b/4, (b%4)*2 + 1), b == 0);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    #2;
    tests++;
    if (img_rdy !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: img_rdy=%b frame_err=%b, required 0 0", img_rdy, frame_err);
    end
    tests++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_counters: frame_cnt=%0d drop_cnt=%0d, required 0 0", frame_cnt, drop_cnt);
    end
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== 8'd0) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_image: %0d nonzero pixels, required 0", bad);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    tests++;
    if (pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: pix_ready=%b, required 1", pix_ready);
    end
  endtask

  task automatic test_basic();
    int bad;
    bad = 0;
    send_range(0, 0, 15);
    tests++;
    if (img_rdy !== 1'b0 || pix_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: img_rdy=%b pix_ready=%b, required 0 0", img_rdy, pix_ready);
    end
    @(posedge clock); #1;
    tests++;
    if (img_rdy !== 1'b1 || frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL basic_fire: img_rdy=%b frame_cnt=%0d, required 1 1", img_rdy, frame_cnt);
    end
    tests++;
    if (laptop_img[3][7] !== 8'd31) begin
      fails++;
      $display("FAIL basic_last_pixel: got %0d, required 31", laptop_img[3][7]);
    end
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== pix(0, r, c)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL basic_image: %0d wrong pixels, required 0", bad);
    end
    @(posedge clock); #1;
    tests++;
    if (img_rdy !== 1'b0 || pix_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_after: img_rdy=%b pix_ready=%b, required 0 1", img_rdy, pix_ready);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    int stalls;
    bad    = 0;
    stalls = 0;
    det_busy = 1'b1;
    send_range(64, 0, 15);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pix_ready !== 1'b0 || img_rdy !== 1'b0) stalls++;
    end
    tests++;
    if (stalls != 0) begin
      fails++;
      $display("FAIL bp_stall: %0d busy cycles with pix_ready or img_rdy high, required 0", stalls);
    end
    @(posedge clock); #1;
    det_busy = 1'b0;
    @(negedge clock);
    tests++;
    if (img_rdy !== 1'b0) begin
      fails++;
      $display("FAIL bp_early: img_rdy=%b one cycle after det_busy fell, required 0", img_rdy);
    end
    @(posedge clock); #1;
    tests++;
    if (img_rdy !== 1'b1 || frame_cnt !== 16'd2) begin
      fails++;
      $display("FAIL bp_fire: img_rdy=%b frame_cnt=%0d, required 1 2", img_rdy, frame_cnt);
    end
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== pix(64, r, c)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_image: %0d wrong pixels, required 0", bad);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_resync();
    int bad;
    bad = 0;
    send_range(100, 0, 4);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL resync_quiet: frame_err=%b before resync, required 0", frame_err);
    end
    send_range(20, 0, 0);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL resync_err: frame_err=%b after second sof, required 1", frame_err);
    end
    send_range(20, 1, 1);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL resync_pulse: frame_err=%b on following cycle, required 0", frame_err);
    end
    send_range(20, 2, 15);
    tests++;
    if (img_rdy !== 1'b0) begin
      fails++;
      $display("FAIL resync_early: img_rdy=%b, required 0", img_rdy);
    end
    @(posedge clock); #1;
    tests++;
    if (img_rdy !== 1'b1 || frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL resync_fire: img_rdy=%b frame_cnt=%0d, required 1 3", img_rdy, frame_cnt);
    end
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== pix(20, r, c)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL resync_image: %0d wrong pixels, required 0", bad);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_mid_reset();
    int bad;
    int pulses;
    bad    = 0;
    pulses = 0;
    send_range(50, 0, 9);
    reset = 1'b1;
    #2;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== 8'd0) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset_image: %0d nonzero pixels, required 0", bad);
    end
    tests++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL midreset_counters: frame_cnt=%0d drop_cnt=%0d, required 0 0", frame_cnt, drop_cnt);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (img_rdy !== 1'b0 || frame_err !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL midreset_pulses: %0d cycles with img_rdy or frame_err, required 0", pulses);
    end
    bad = 0;
    send_range(7, 0, 15);
    @(posedge clock); #1;
    tests++;
    if (img_rdy !== 1'b1 || frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL midreset_fire: img_rdy=%b frame_cnt=%0d, required 1 1", img_rdy, frame_cnt);
    end
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== pix(7, r, c)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset_image2: %0d wrong pixels, required 0", bad);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_dropped();
    int bad;
    bad = 0;
    send_beat(8'hAA, 8'hBB, 1'b0);
    send_beat(8'hCC, 8'hDD, 1'b0);
    send_beat(8'hEE, 8'hFF, 1'b0);
    tests++;
    if (drop_cnt !== 16'd3) begin
      fails++;
      $display("FAIL drop_count: drop_cnt=%0d, required 3", drop_cnt);
    end
    send_range(200, 0, 15);
    @(posedge clock); #1;
    tests++;
    if (img_rdy !== 1'b1 || frame_cnt !== 16'd2 || drop_cnt !== 16'd3) begin
      fails++;
      $display("FAIL drop_frame: img_rdy=%b frame_cnt=%0d drop_cnt=%0d, required 1 2 3",
               img_rdy, frame_cnt, drop_cnt);
    end
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        if (laptop_img[r][c] !== pix(200, r, c)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL drop_image: %0d wrong pixels, required 0", bad);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset     = 1'b1;
    pix_data  = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    det_busy  = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_mid_reset();
    test_dropped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
